// File: rtl/code_loader.sv
// Purpose : shares the code memory control inputs between CPU instruction
//           fetch (IDLE passthrough) and a sequential user-program download
//           into addresses BASE_ADDR..LAST_ADDR.
// Latency : a word accepted at edge N is driven to memory during N..N+1.
//           Last acceptance at L gives FLUSH L..L+1, DONE L+1..L+2, IDLE from L+2.
// Backpressure: in_ready is high only in LOAD while capacity remains and no
//           abort is being taken; it is low in every other state.
//
// Ports:
//   clock, reset (async, active-low)
//   cpu_run_req, pc                      CPU side: run switch and fetch address
//   load_start, load_abort               download control
//   in_valid/in_data/in_last, in_ready   word stream handshake
//   mem_run, mem_c1, mem_write_select,
//   mem_inp, mem_read_select             code memory control inputs
//   cpu_stall, busy, done, full_err,
//   abort_err, words_loaded              status
module code_loader #(
    parameter int BASE_ADDR = 32,
    parameter int LAST_ADDR = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_run_req,
    input  logic [5:0]  pc,
    input  logic        load_start,
    input  logic        load_abort,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_run,
    output logic        mem_c1,
    output logic [5:0]  mem_write_select,
    output logic [15:0] mem_inp,
    output logic [5:0]  mem_read_select,
    output logic        cpu_stall,
    output logic        busy,
    output logic        done,
    output logic        full_err,
    output logic        abort_err,
    output logic [5:0]  words_loaded
);

    localparam int          CAP       = LAST_ADDR - BASE_ADDR + 1;
    localparam logic [5:0]  CAP_W     = 6'(CAP);
    localparam logic [5:0]  BASE_W    = 6'(BASE_ADDR);
    localparam logic [5:0]  LAST_SLOT = 6'(CAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t      state_q;
    logic [5:0]  held_pc_q;
    logic [5:0]  words_q;
    logic        c1_q;
    logic [5:0]  wsel_q;
    logic [15:0] inp_q;
    logic        stall_q;
    logic        busy_q;
    logic        done_q;
    logic        full_q;
    logic        abort_q;
    logic        accept;

    // An abort in the same cycle as a valid word wins: ready is withdrawn so
    // the source keeps its word and no write is issued.
    assign in_ready = (state_q == ST_LOAD) && (words_q < CAP_W) && !load_abort;
    assign accept   = in_valid && in_ready;

    // Fetch passthrough only in IDLE; otherwise run stays high so the memory
    // honours c1, and the read port is parked on the PC captured at start.
    assign mem_run         = (state_q == ST_IDLE) ? cpu_run_req : 1'b1;
    assign mem_read_select = (state_q == ST_IDLE) ? pc : held_pc_q;

    assign mem_c1           = c1_q;
    assign mem_write_select = wsel_q;
    assign mem_inp          = inp_q;
    assign cpu_stall        = stall_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign full_err         = full_q;
    assign abort_err        = abort_q;
    assign words_loaded     = words_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            held_pc_q <= '0;
            words_q   <= '0;
            c1_q      <= 1'b0;
            wsel_q    <= '0;
            inp_q     <= '0;
            stall_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            full_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            // Write strobe and done are single-cycle pulses by default.
            c1_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q   <= ST_LOAD;
                        held_pc_q <= pc;
                        words_q   <= '0;
                        full_q    <= 1'b0;
                        abort_q   <= 1'b0;
                        stall_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_abort) begin
                        abort_q <= 1'b1;
                        state_q <= ST_FLUSH;
                    end else if (accept) begin
                        c1_q    <= 1'b1;
                        wsel_q  <= BASE_W + words_q;
                        inp_q   <= in_data;
                        words_q <= words_q + 6'd1;
                        if (in_last) begin
                            state_q <= ST_FLUSH;
                        end else if (words_q == LAST_SLOT) begin
                            // Region filled without an end marker.
                            full_q  <= 1'b1;
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The final registered write lands during this cycle.
                    state_q <= ST_DONE;
                    done_q  <= !full_q && !abort_q;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader: table-driven IDLE passthrough vectors, hand-written
// reset/normal/gapped/overflow/abort downloads, and randomized downloads whose
// outcome is predicted from the scenario (words, end marker, abort point).
module tb_code_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_run_req = 1'b0;
    logic [5:0]  pc = '0;
    logic        load_start = 1'b0;
    logic        load_abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready, mem_run, mem_c1, cpu_stall, busy, done, full_err, abort_err;
    logic [5:0]  mem_write_select, mem_read_select, words_loaded;
    logic [15:0] mem_inp;

    code_loader #(.BASE_ADDR(32), .LAST_ADDR(63)) dut (
        .clock(clock), .reset(reset), .cpu_run_req(cpu_run_req), .pc(pc),
        .load_start(load_start), .load_abort(load_abort),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_run(mem_run), .mem_c1(mem_c1), .mem_write_select(mem_write_select),
        .mem_inp(mem_inp), .mem_read_select(mem_read_select),
        .cpu_stall(cpu_stall), .busy(busy), .done(done),
        .full_err(full_err), .abort_err(abort_err), .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;   // index of the most recent rising edge; read only at negedge

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural code memory plus bus monitor.
    logic [15:0] bmem [0:63];
    logic [5:0]  obs_addr[$];
    logic [15:0] obs_data[$];
    int          obs_cyc[$];
    bit          mon_en = 1'b0;
    logic [5:0]  held_exp = '0;
    int          viol_rsel, viol_run, viol_low, done_cnt, done_cyc;

    always @(negedge clock) begin
        if (mem_c1 === 1'b1) begin
            obs_addr.push_back(mem_write_select);
            obs_data.push_back(mem_inp);
            obs_cyc.push_back(cyc);
            if (mem_run === 1'b1) bmem[mem_write_select] = mem_inp;
            if (mem_write_select < 6'd32) viol_low++;
        end
        if (mon_en) begin
            if (busy === 1'b1 && mem_read_select !== held_exp) viol_rsel++;
            if (busy === 1'b1 && mem_run !== 1'b1) viol_run++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // One download scenario. lastpos: index carrying in_last (-1 none);
    // abortpos: abort once that many words are accepted (-1 none);
    // gapsel: idle cycles before each word after the first (-1 random).
    task automatic download(input string tag, input int lastpos, input int abortpos, input int gapsel);
        logic [15:0] w [40];
        int  acc_cyc[$];
        int  nat_end, exp_n, end_edge, stall_low, extra_rdy, gap;
        bit  do_abort, exp_full, exp_done, tmo, hs;
        for (int i = 0; i < 40; i++) w[i] = 16'($urandom);
        nat_end  = (lastpos >= 0 && lastpos < 32) ? lastpos + 1 : 32;
        do_abort = (abortpos >= 0 && abortpos < nat_end);
        exp_n    = do_abort ? abortpos : nat_end;
        exp_full = !do_abort && !(lastpos >= 0 && lastpos < 32);
        exp_done = !do_abort && !exp_full;
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        viol_rsel = 0; viol_run = 0; viol_low = 0; done_cnt = 0; done_cyc = -1;
        tmo = 1'b0; end_edge = -1;

        @(negedge clock);
        pc = 6'($urandom); held_exp = pc; load_start = 1'b1;
        in_valid = 1'b0; load_abort = 1'b0; in_last = 1'b0;
        @(negedge clock);
        load_start = 1'b0; mon_en = 1'b1;
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_stall_after_start"}, cpu_stall, 1);
        chk({tag, "_ready_after_start"}, in_ready, 1);
        chk({tag, "_count_cleared"}, words_loaded, 0);

        for (int i = 0; i < exp_n && !tmo; i++) begin
            gap = (gapsel < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gapsel);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; pc = 6'($urandom);
                @(negedge clock);
            end
            in_valid = 1'b1; in_data = w[i]; in_last = (i == lastpos);
            hs = 1'b0;
            for (int t = 0; t < 20 && !hs; t++) begin
                pc = 6'($urandom);
                #1 hs = (in_ready === 1'b1);
                @(negedge clock);
            end
            if (!hs) begin
                chk({tag, "_handshake_timeout"}, 0, 1);
                tmo = 1'b1;
            end else begin
                acc_cyc.push_back(cyc);
                end_edge = cyc;
            end
            in_valid = 1'b0; in_last = 1'b0;
        end
        if (do_abort && !tmo) begin
            gap = (gapsel < 0) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gap; g++) @(negedge clock);
            in_valid = 1'b1; in_data = w[exp_n]; load_abort = 1'b1;
            @(negedge clock);
            end_edge = cyc; load_abort = 1'b0;
        end
        if (end_edge < 0) end_edge = cyc;

        // Keep offering a word after the end: nothing more may be accepted.
        in_valid = 1'b1; in_data = w[39]; in_last = 1'b0;
        stall_low = -1; extra_rdy = 0;
        for (int t = 0; t < 6; t++) begin
            #1 if (in_ready === 1'b1) extra_rdy++;
            @(negedge clock);
            if (stall_low < 0 && cpu_stall === 1'b0) stall_low = cyc;
        end
        in_valid = 1'b0; mon_en = 1'b0;

        chk({tag, "_write_count"}, obs_addr.size(), exp_n);
        for (int i = 0; i < exp_n && i < obs_addr.size() && i < acc_cyc.size(); i++) begin
            chk({tag, "_wr_addr"}, obs_addr[i], 32 + i);
            chk({tag, "_wr_data"}, obs_data[i], w[i]);
            chk({tag, "_wr_cycle"}, obs_cyc[i], acc_cyc[i]);
        end
        chk({tag, "_words_loaded"}, words_loaded, exp_n);
        chk({tag, "_full_err"}, full_err, exp_full);
        chk({tag, "_abort_err"}, abort_err, do_abort);
        chk({tag, "_done_pulses"}, done_cnt, exp_done);
        if (exp_done) chk({tag, "_done_cycle"}, done_cyc, end_edge + 1);
        chk({tag, "_stall_low_cycle"}, stall_low, end_edge + 2);
        chk({tag, "_late_ready"}, extra_rdy, 0);
        chk({tag, "_held_pc"}, viol_rsel, 0);
        chk({tag, "_run_high"}, viol_run, 0);
        chk({tag, "_bios_write"}, viol_low, 0);
        // Fetch back through the passthrough read port.
        for (int i = 0; i < exp_n; i++) begin
            pc = 6'(32 + i);
            #1 chk({tag, "_readback"}, bmem[mem_read_select], w[i]);
        end
    endtask

    typedef struct {
        logic       run;
        logic [5:0] pcv;
        logic       vld;
        logic       exp_run;
        logic [5:0] exp_rsel;
    } pt_vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pt_vec_t vec [9];
        vec[0] = '{1'b1, 6'd0,  1'b0, 1'b1, 6'd0};
        vec[1] = '{1'b1, 6'd1,  1'b1, 1'b1, 6'd1};
        vec[2] = '{1'b1, 6'd2,  1'b0, 1'b1, 6'd2};
        vec[3] = '{1'b1, 6'd3,  1'b1, 1'b1, 6'd3};
        vec[4] = '{1'b1, 6'd4,  1'b0, 1'b1, 6'd4};
        vec[5] = '{1'b1, 6'd5,  1'b0, 1'b1, 6'd5};
        vec[6] = '{1'b0, 6'd17, 1'b1, 1'b0, 6'd17};
        vec[7] = '{1'b0, 6'd63, 1'b0, 1'b0, 6'd63};
        vec[8] = '{1'b1, 6'd42, 1'b1, 1'b1, 6'd42};

        // Reset state.
        cpu_run_req = 1'b1; pc = 6'd9;
        repeat (2) @(negedge clock);
        chk("rst_c1", mem_c1, 0);
        chk("rst_count", words_loaded, 0);
        chk("rst_flags", {full_err, abort_err, done}, 0);
        chk("rst_ready_stall_busy", {in_ready, cpu_stall, busy}, 0);
        chk("rst_wsel", mem_write_select, 0);
        chk("rst_inp", mem_inp, 0);
        chk("rst_run_pass", mem_run, 1);
        chk("rst_rsel_pass", mem_read_select, 9);
        reset = 1'b1;
        @(negedge clock);

        // IDLE passthrough table.
        for (int i = 0; i < 9; i++) begin
            cpu_run_req = vec[i].run; pc = vec[i].pcv; in_valid = vec[i].vld;
            #1;
            chk("pt_run", mem_run, vec[i].exp_run);
            chk("pt_rsel", mem_read_select, vec[i].exp_rsel);
            chk("pt_c1", mem_c1, 0);
            chk("pt_ready", in_ready, 0);
            chk("pt_stall", cpu_stall, 0);
            @(negedge clock);
        end
        in_valid = 1'b0;

        // Reset while a write strobe is active.
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF;
        @(negedge clock);
        chk("rml_c1_before", mem_c1, 1);
        in_valid = 1'b0; reset = 1'b0;
        #1;
        chk("rml_c1_async", mem_c1, 0);
        chk("rml_count", words_loaded, 0);
        chk("rml_busy", busy, 0);
        chk("rml_stall", cpu_stall, 0);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b1;
        @(negedge clock);
        #1 chk("rml_idle_ready", in_ready, 0);
        chk("rml_idle_busy", busy, 0);
        in_valid = 1'b0;

        // Hand-written corner scenarios.
        download("normal3", 2, -1, 0);
        download("gapped", 1, -1, 2);
        download("overflow", -1, -1, 0);
        download("abort5", -1, 5, 0);
        download("abort0", -1, 0, 0);
        download("last32", 31, -1, 0);

        // Randomized scenarios.
        for (int r = 0; r < 20; r++) begin
            int lp, ap;
            lp = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 35));
            ap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 33)) : -1;
            cpu_run_req = 1'($urandom);
            download("rand", lp, ap, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
